// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared widths and types for the register-file writeback path
// Rev 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSU = 1'b1
   } wb_src_e;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
// ============================================================================
// regfile_wb_arbiter_if : two writeback request channels plus the registered
// register-file write port.   Rev 1.0
// ============================================================================
`default_nettype none

interface regfile_wb_arbiter_if #(
   parameter int XLEN       = regfile_pkg::XLEN,
   parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W
);

   logic                  s0_valid;
   logic [REG_ADDR_W-1:0] s0_rd;
   logic [XLEN-1:0]       s0_data;
   logic                  s0_ready;

   logic                  s1_valid;
   logic [REG_ADDR_W-1:0] s1_rd;
   logic [XLEN-1:0]       s1_data;
   logic                  s1_ready;

   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_waddr;
   logic [XLEN-1:0]       rf_wdata;
   logic                  starve_boost;

   modport master (
      output s0_valid, s0_rd, s0_data, s1_valid, s1_rd, s1_data,
      input  s0_ready, s1_ready, rf_we, rf_waddr, rf_wdata, starve_boost
   );

   modport slave (
      input  s0_valid, s0_rd, s0_data, s1_valid, s1_rd, s1_data,
      output s0_ready, s1_ready, rf_we, rf_waddr, rf_wdata, starve_boost
   );

endinterface

`default_nettype wire

// File: rtl/regfile_bypass_mux.sv
// ============================================================================
// regfile_bypass_mux : forwards the in-flight write to one asynchronous read
// port while the register file still returns the old value.   Rev 1.0
// ============================================================================
`default_nettype none

module regfile_bypass_mux #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  rf_we,
   input  logic [REG_ADDR_W-1:0] rf_waddr,
   input  logic [XLEN-1:0]       rf_wdata,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   input  logic [XLEN-1:0]       rf_rdata,
   output logic [XLEN-1:0]       byp_data
);

   logic w_hit;

   // x0 reads are never forwarded; the port never writes x0 anyway
   assign w_hit    = rf_we && (rf_waddr == rd_addr) && (rd_addr != '0);
   assign byp_data = w_hit ? rf_wdata : rf_rdata;

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// regfile_wb_arbiter : shares the register-file write port between ALU (src0)
// and LSU (src1); optional read bypass under macro WB_BYPASS_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
   parameter int XLEN         = regfile_pkg::XLEN,
   parameter int REG_ADDR_W   = regfile_pkg::REG_ADDR_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
`ifdef WB_BYPASS_EN
   input  logic [REG_ADDR_W-1:0] rd_addr1,
   input  logic [REG_ADDR_W-1:0] rd_addr2,
   input  logic [XLEN-1:0]       rf_rdata1,
   input  logic [XLEN-1:0]       rf_rdata2,
   output logic [XLEN-1:0]       byp_data1,
   output logic [XLEN-1:0]       byp_data2,
`endif
   regfile_wb_arbiter_if.slave   wb
);

   import regfile_pkg::*;

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] C_STARVE_LIMIT = CNT_W'(STARVE_LIMIT);

   logic                  w_real0;
   logic                  w_real1;
   logic                  w_boost;
   logic                  w_grant0;
   logic                  w_grant1;
   logic                  w_grant_any;
   wb_src_e               w_grant_src;
   logic [REG_ADDR_W-1:0] w_grant_rd;
   logic [XLEN-1:0]       w_grant_data;

   logic [CNT_W-1:0]      r_starve_cnt;
   logic                  r_rf_we;
   logic [REG_ADDR_W-1:0] r_rf_waddr;
   logic [XLEN-1:0]       r_rf_wdata;

   // Requests to x0 bypass arbitration entirely
   assign w_real0     = wb.s0_valid && (wb.s0_rd != '0);
   assign w_real1     = wb.s1_valid && (wb.s1_rd != '0);
   assign w_boost     = (r_starve_cnt == C_STARVE_LIMIT);
   assign w_grant0    = w_real0 && (w_boost || !w_real1);
   assign w_grant1    = w_real1 && !w_grant0;
   assign w_grant_any = w_grant0 || w_grant1;

   assign wb.s0_ready     = !reset && wb.s0_valid && (!w_real0 || w_grant0);
   assign wb.s1_ready     = !reset && wb.s1_valid && (!w_real1 || w_grant1);
   assign wb.starve_boost = w_boost;

   always_comb begin
      w_grant_src  = SRC_LSU;
      w_grant_rd   = wb.s1_rd;
      w_grant_data = wb.s1_data;
      if (w_grant0) begin
         w_grant_src  = SRC_ALU;
         w_grant_rd   = wb.s0_rd;
         w_grant_data = wb.s0_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_starve_cnt <= '0;
         r_rf_we      <= 1'b0;
         r_rf_waddr   <= '0;
         r_rf_wdata   <= '0;
      end else begin
         r_rf_we <= w_grant_any;
         if (w_grant_any) begin
            r_rf_waddr <= w_grant_rd;
            r_rf_wdata <= w_grant_data;
         end
         // Counts consecutive denials of a real src0 request, saturating
         if (w_real0 && (w_grant_src != SRC_ALU || !w_grant_any)) begin
            if (r_starve_cnt != C_STARVE_LIMIT)
               r_starve_cnt <= r_starve_cnt + CNT_W'(1);
         end else begin
            r_starve_cnt <= '0;
         end
      end
   end

   assign wb.rf_we    = r_rf_we;
   assign wb.rf_waddr = r_rf_waddr;
   assign wb.rf_wdata = r_rf_wdata;

`ifdef WB_BYPASS_EN
   regfile_bypass_mux #(
      .XLEN       (XLEN),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_byp1 (
      .rf_we    (r_rf_we),
      .rf_waddr (r_rf_waddr),
      .rf_wdata (r_rf_wdata),
      .rd_addr  (rd_addr1),
      .rf_rdata (rf_rdata1),
      .byp_data (byp_data1)
   );

   regfile_bypass_mux #(
      .XLEN       (XLEN),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_byp2 (
      .rf_we    (r_rf_we),
      .rf_waddr (r_rf_waddr),
      .rf_wdata (r_rf_wdata),
      .rd_addr  (rd_addr2),
      .rf_rdata (rf_rdata2),
      .byp_data (byp_data2)
   );
`endif

endmodule

`default_nettype wire
